// File: rtl/apb_master_bridge.sv
// APB3 master bridge: turns single-beat valid/ready commands into SETUP/ACCESS transfers.
// Optional macro APB_TIMEOUT_EN bounds ACCESS wait states and reports a timeout through resp_err.
module apb_master_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             resp_err_q, resp_err_d;
`else
    // Wait-state limit only matters when the timeout counter is built.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        resp_err_d   = resp_err_q;
`endif

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    pwrite_d    = req_write;
                    paddr_d     = req_addr;
                    pwdata_d    = req_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    req_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ACCESS: begin
                // A ready slave on the limit cycle still completes normally.
                if (pready) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_rdata_d = pwrite_q ? '0 : prdata;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
`ifdef APB_TIMEOUT_EN
                    resp_err_d   = 1'b0;
`endif
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
`ifdef APB_TIMEOUT_EN
    assign resp_err   = resp_err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
